// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared types and constants for the LSU port arbiter.
//   lsu_req_t - one requester's transfer fields, bundled per port
//   N_PORTS   - number of requesters sharing the LSU (core MEM stage, debug/DMA)
//   FUNCT3_LW - RISC-V funct3 code for a 32-bit load
package lsu_arb_pkg;

    localparam int         N_PORTS   = 2;
    localparam logic [2:0] FUNCT3_LW = 3'b010;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic [2:0]  funct3;
        logic        lock;
    } lsu_req_t;

endpackage

// File: rtl/lsu_arb_grant.sv
// lsu_arb_grant: purely combinational winner selection for the two-port
// LSU arbiter.
//   valid_i      - per-port request valid
//   pref_i       - port that wins when both are valid and no lock is held
//   lock_held_i  - a locked sequence is in progress
//   lock_owner_i - port that owns the lock
//   gnt_o        - one-hot (or zero) grant, only ever set on a valid port
module lsu_arb_grant (
    input  logic [1:0] valid_i,
    input  logic       pref_i,
    input  logic       lock_held_i,
    input  logic       lock_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (lock_held_i) begin
            // The non-owner stalls even while the owner is idle.
            gnt_o[lock_owner_i] = valid_i[lock_owner_i];
        end else if (valid_i == 2'b11) begin
            gnt_o[pref_i] = 1'b1;
        end else begin
            gnt_o = valid_i;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares the LSU data-memory/MMIO port between the core MEM
// stage (port 0) and a debug/DMA master (port 1).
//   i_clk, i_reset       - clock, synchronous active-high reset
//   i_req_*              - per-port valid/addr/wdata/wren/funct3/lock
//   o_req_ready          - per-port grant (transfer = valid & ready)
//   o_rsp_valid          - one-cycle response pulse to the issuing port
//   o_rsp_rdata          - load data for reads, zero for stores
//   o_lsu_*              - drive of the LSU for the current winner
//   i_ld_data            - LSU load data, valid the cycle after the read
// Build option: define LSU_ARB_FIXED_PRIO_EN for fixed port-0 priority with a
// port-1 starvation limit of P_MAX_WAIT cycles; otherwise round-robin.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int P_MAX_WAIT = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [1:0]      i_req_valid,
    input  logic [1:0][31:0] i_req_addr,
    input  logic [1:0][31:0] i_req_wdata,
    input  logic [1:0]      i_req_wren,
    input  logic [1:0][2:0] i_req_funct3,
    input  logic [1:0]      i_req_lock,
    output logic [1:0]      o_req_ready,
    output logic [1:0]      o_rsp_valid,
    output logic [31:0]     o_rsp_rdata,
    output logic [31:0]     o_lsu_addr,
    output logic [31:0]     o_lsu_st_data,
    output logic            o_lsu_wren,
    output logic            o_lsu_ren,
    output logic [2:0]      o_lsu_funct3,
    input  logic [31:0]     i_ld_data
);

    if (P_MAX_WAIT < 1 || P_MAX_WAIT > 255) begin : g_bad_max_wait
        $error("lsu_arbiter: P_MAX_WAIT must be in 1..255");
    end

    lsu_req_t   req [N_PORTS];
    logic [1:0] gnt_raw;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       sel;
    logic       pref;

    logic lock_held_q, lock_held_d;
    logic lock_owner_q, lock_owner_d;
    logic rsp_pend_q, rsp_pend_d;
    logic rsp_port_q, rsp_port_d;
    logic rsp_is_read_q, rsp_is_read_d;

    always_comb begin
        for (int k = 0; k < N_PORTS; k++) begin
            req[k].valid  = i_req_valid[k];
            req[k].addr   = i_req_addr[k];
            req[k].wdata  = i_req_wdata[k];
            req[k].wren   = i_req_wren[k];
            req[k].funct3 = i_req_funct3[k];
            req[k].lock   = i_req_lock[k];
        end
    end

`ifdef LSU_ARB_FIXED_PRIO_EN
    logic [7:0] wait_q, wait_d;

    // Port 0 wins contention until port 1 has waited P_MAX_WAIT cycles.
    assign pref = (wait_q >= 8'(P_MAX_WAIT));

    always_comb begin
        wait_d = wait_q;
        if (gnt[1]) begin
            wait_d = 8'd0;
        end else if (req[1].valid && wait_q != 8'hFF) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) wait_q <= 8'd0;
        else         wait_q <= wait_d;
    end
`else
    logic rr_ptr_q, rr_ptr_d;

    assign pref     = rr_ptr_q;
    assign rr_ptr_d = any_gnt ? ~sel : rr_ptr_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) rr_ptr_q <= 1'b0;
        else         rr_ptr_q <= rr_ptr_d;
    end
`endif

    lsu_arb_grant u_grant (
        .valid_i      ({req[1].valid, req[0].valid}),
        .pref_i       (pref),
        .lock_held_i  (lock_held_q),
        .lock_owner_i (lock_owner_q),
        .gnt_o        (gnt_raw)
    );

    // No transfer is accepted while reset is asserted.
    assign gnt     = gnt_raw & {2{~i_reset}};
    assign any_gnt = |gnt;
    assign sel     = gnt[1];   // port 0 fields when nobody is granted

    assign o_req_ready   = gnt;
    assign o_lsu_addr    = req[sel].addr;
    assign o_lsu_st_data = req[sel].wdata;
    assign o_lsu_funct3  = req[sel].funct3;
    assign o_lsu_wren    = any_gnt &  req[sel].wren;
    assign o_lsu_ren     = any_gnt & ~req[sel].wren;

    always_comb begin
        lock_held_d  = lock_held_q;
        lock_owner_d = lock_owner_q;
        if (any_gnt) begin
            if (req[sel].lock) begin
                lock_held_d  = 1'b1;
                lock_owner_d = sel;
            end else if (lock_owner_q == sel) begin
                lock_held_d  = 1'b0;
            end
        end
    end

    // Response bookkeeping is rewritten every cycle; an idle cycle leaves
    // no response pending for the next one.
    assign rsp_pend_d    = any_gnt;
    assign rsp_port_d    = any_gnt ? sel : rsp_port_q;
    assign rsp_is_read_d = any_gnt & ~req[sel].wren;

    // ---- request cycle -> response cycle ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lock_held_q   <= 1'b0;
            lock_owner_q  <= 1'b0;
            rsp_pend_q    <= 1'b0;
            rsp_port_q    <= 1'b0;
            rsp_is_read_q <= 1'b0;
        end else begin
            lock_held_q   <= lock_held_d;
            lock_owner_q  <= lock_owner_d;
            rsp_pend_q    <= rsp_pend_d;
            rsp_port_q    <= rsp_port_d;
            rsp_is_read_q <= rsp_is_read_d;
        end
    end

    // Reset also masks a response that was registered just before it.
    assign o_rsp_valid = (rsp_pend_q & ~i_reset) ? (rsp_port_q ? 2'b10 : 2'b01) : 2'b00;
    assign o_rsp_rdata = (rsp_is_read_q & ~i_reset) ? i_ld_data : 32'h0;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the arbitration rules.
module tb_lsu_arbiter;
    import lsu_arb_pkg::*;

    localparam int P_MAX_WAIT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       valid = '0;
    logic [1:0][31:0] addr = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0]       wren = '0;
    logic [1:0][2:0]  f3 = '0;
    logic [1:0]       lock = '0;
    logic [31:0]      ld = '0;
    logic [1:0]       ready, rsp_valid;
    logic [31:0]      rsp_rdata, lsu_addr, lsu_st_data;
    logic             lsu_wren, lsu_ren;
    logic [2:0]       lsu_funct3;

    always #5 clk = ~clk;

    lsu_arbiter #(.P_MAX_WAIT(P_MAX_WAIT)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_req_valid   (valid),
        .i_req_addr    (addr),
        .i_req_wdata   (wdata),
        .i_req_wren    (wren),
        .i_req_funct3  (f3),
        .i_req_lock    (lock),
        .o_req_ready   (ready),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_lsu_addr    (lsu_addr),
        .o_lsu_st_data (lsu_st_data),
        .o_lsu_wren    (lsu_wren),
        .o_lsu_ren     (lsu_ren),
        .o_lsu_funct3  (lsu_funct3),
        .i_ld_data     (ld)
    );

    int n_vec = 0;
    int n_err = 0;

    // Stimulus staging, copied onto the DUT inputs at the falling edge.
    bit        s_rst;
    bit [1:0]  s_v, s_we, s_lk;
    bit [31:0] s_a [2];
    bit [31:0] s_wd [2];
    bit [2:0]  s_f3 [2];
    bit [31:0] s_ld;

    // Model state: who is favoured next, lock ownership, pending response.
    bit m_next, m_locked, m_owner, m_rsp_pend, m_rsp_port, m_rsp_rd;
    int m_wait;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        s_rst = 1'b0; s_v = '0; s_we = '0; s_lk = '0; s_ld = '0;
        for (int p = 0; p < 2; p++) begin
            s_a[p] = '0; s_wd[p] = '0; s_f3[p] = FUNCT3_LW;
        end
    endtask

    function automatic bit contention_winner();
`ifdef LSU_ARB_FIXED_PRIO_EN
        return (m_wait >= P_MAX_WAIT);
`else
        return m_next;
`endif
    endfunction

    // One clock: apply stimulus, check every output against the model,
    // then advance the model to what the next cycle must look like.
    task automatic step();
        bit has_win, win, idx;
        logic [1:0] e_rdy, e_rsp;
        @(negedge clk);
        rst = s_rst; valid = s_v; wren = s_we; lock = s_lk; ld = s_ld;
        for (int p = 0; p < 2; p++) begin
            addr[p] = s_a[p]; wdata[p] = s_wd[p]; f3[p] = s_f3[p];
        end
        #1;
        has_win = 1'b0; win = 1'b0;
        if (!s_rst) begin
            if (m_locked) begin
                if (s_v[m_owner]) begin has_win = 1'b1; win = m_owner; end
            end else begin
                case (s_v)
                    2'b01:   begin has_win = 1'b1; win = 1'b0; end
                    2'b10:   begin has_win = 1'b1; win = 1'b1; end
                    2'b11:   begin has_win = 1'b1; win = contention_winner(); end
                    default: ;
                endcase
            end
        end
        idx   = has_win & win;
        e_rdy = has_win ? (win ? 2'b10 : 2'b01) : 2'b00;
        e_rsp = (!s_rst && m_rsp_pend) ? (m_rsp_port ? 2'b10 : 2'b01) : 2'b00;
        chk("ready",     32'(ready),       32'(e_rdy));
        chk("lsu_wren",  32'(lsu_wren),    32'(has_win && s_we[idx]));
        chk("lsu_ren",   32'(lsu_ren),     32'(has_win && !s_we[idx]));
        chk("lsu_addr",  lsu_addr,         s_a[idx]);
        chk("lsu_wdata", lsu_st_data,      s_wd[idx]);
        chk("lsu_f3",    32'(lsu_funct3),  32'(s_f3[idx]));
        chk("rsp_valid", 32'(rsp_valid),   32'(e_rsp));
        if (s_rst)           chk("rsp_rdata_rst", rsp_rdata, 32'h0);
        else if (m_rsp_pend) chk("rsp_rdata", rsp_rdata, m_rsp_rd ? s_ld : 32'h0);

        if (s_rst) begin
            m_next = 1'b0; m_locked = 1'b0; m_rsp_pend = 1'b0; m_wait = 0;
        end else begin
            if (has_win && win)             m_wait = 0;
            else if (s_v[1] && m_wait < 255) m_wait++;
            m_rsp_pend = has_win;
            if (has_win) begin
                m_rsp_port = win;
                m_rsp_rd   = !s_we[win];
                m_next     = ~win;
                if (s_lk[win]) begin m_locked = 1'b1; m_owner = win; end
                else           m_locked = 1'b0;
            end
        end
    endtask

    initial begin
        idle();
        s_rst = 1'b1;
        step();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_ready",     32'(ready),     32'h0);
        step();

        // Port 0 word load, data comes back one cycle later.
        idle(); s_v = 2'b01; s_a[0] = 32'h10; s_f3[0] = FUNCT3_LW;
        step();
        chk("ld_ready", 32'(ready), 32'h1);
        idle(); s_ld = 32'hDEADBEEF;
        step();
        chk("ld_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ld_rsp_data",  rsp_rdata,      32'hDEADBEEF);

        // Continuous contention from a fresh reset.
        idle(); s_rst = 1'b1; step();
`ifndef LSU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) begin
            idle(); s_v = (i < 4) ? 2'b11 : 2'b00; s_ld = 32'h100 + 32'(i);
            step();
            if (i < 4) chk("rr_grant", 32'(ready), (i % 2 == 1) ? 32'h2 : 32'h1);
            if (i > 0) chk("rr_rsp", 32'(rsp_valid), (i % 2 == 0) ? 32'h2 : 32'h1);
        end

        // Locked read-modify-write from port 1 while port 0 keeps asking.
        idle(); s_rst = 1'b1; step();
        idle(); s_v = 2'b01; step();
        chk("lk_pre", 32'(ready), 32'h1);
        idle(); s_v = 2'b11; s_lk = 2'b10; s_a[1] = 32'h100; step();
        chk("lk_load", 32'(ready), 32'h2);
        idle(); s_v = 2'b01; step();
        chk("lk_owner_idle", 32'(ready), 32'h0);
        idle(); s_v = 2'b11; s_we = 2'b10; s_a[1] = 32'h100; s_wd[1] = 32'h55; step();
        chk("lk_release", 32'(ready), 32'h2);
        idle(); s_v = 2'b01; s_ld = 32'hCAFEF00D; step();
        chk("lk_after", 32'(ready), 32'h1);
        chk("lk_st_rsp", 32'(rsp_valid), 32'h2);
        chk("lk_st_data", rsp_rdata, 32'h0);
`else
        for (int i = 0; i < P_MAX_WAIT + 1; i++) begin
            idle(); s_v = 2'b11; step();
            chk("fp_grant", 32'(ready), (i == P_MAX_WAIT) ? 32'h2 : 32'h1);
        end
`endif

        // Reset right after a transfer drops its response.
        idle(); s_v = 2'b01; step();
        chk("rst_mid_xfer", 32'(ready), 32'h1);
        idle(); s_rst = 1'b1; s_v = 2'b11; s_ld = 32'h1234; step();
        chk("rst_mid_rsp",   32'(rsp_valid), 32'h0);
        chk("rst_mid_grant", 32'(ready),     32'h0);
        step();

        // Reset releases a held lock.
        idle(); s_v = 2'b10; s_lk = 2'b10; step();
        idle(); s_rst = 1'b1; step();
        idle(); s_v = 2'b01; step();
        chk("rst_unlock", 32'(ready), 32'h1);

        // Port 1 store to MMIO space.
        idle(); s_v = 2'b10; s_we = 2'b10; s_a[1] = 32'h1000_0000; s_wd[1] = 32'hAA; step();
        chk("st_wren", 32'(lsu_wren), 32'h1);
        chk("st_addr", lsu_addr, 32'h1000_0000);
        chk("st_data", lsu_st_data, 32'hAA);
        idle(); s_ld = 32'h1234_5678; step();
        chk("st_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("st_rsp_data",  rsp_rdata,      32'h0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            s_rst = ($urandom_range(0, 99) == 0);
            s_v   = 2'($urandom);
            s_we  = 2'($urandom);
            s_lk  = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            s_ld  = $urandom;
            for (int p = 0; p < 2; p++) begin
                s_a[p] = $urandom; s_wd[p] = $urandom; s_f3[p] = 3'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-port arbiter that shares the single data-memory/MMIO port of the pipelined core's load-store unit between the core MEM stage (port 0) and a debug/DMA master (port 1). Each request is a valid/ready transfer. The arbiter drives the LSU control inputs for the winner and routes the LSU's one-cycle-latency synchronous load data back to the issuing port as a tagged response. A lock qualifier supports read-modify-write sequences that the other port must not interleave.

## Interface
Parameters:
- P_MAX_WAIT, 8: starvation limit in cycles for port 1. Used only when fixed priority is compiled in. Legal range 1..255.

Ports:
- i_clk  in  1  clock; every register updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  2  per-port request valid; bit k belongs to port k.
- i_req_addr  in  2x32  byte address per port.
- i_req_wdata  in  2x32  store data per port.
- i_req_wren  in  2  1 = store, 0 = load.
- i_req_funct3  in  2x3  RISC-V size/sign code; passed through unchanged.
- i_req_lock  in  2  keeps the grant on this port after this transfer.
- o_req_ready  out  2  grant; a transfer happens when valid & ready.
- o_rsp_valid  out  2  one-cycle response pulse per port.
- o_rsp_rdata  out  32  response data, shared by both ports.
- o_lsu_addr  out  32  to the LSU address input.
- o_lsu_st_data  out  32  to the LSU store-data input.
- o_lsu_wren  out  1  to the LSU write enable.
- o_lsu_ren  out  1  to the LSU read enable.
- o_lsu_funct3  out  3  to the LSU funct3 input.
- i_ld_data  in  32  from the LSU load-data output; registered inside the LSU.

## Operation
- Arbitration is combinational within the cycle. At most one bit of o_req_ready is high.
- o_req_ready[k] may depend on i_req_valid. It is high only when i_req_valid[k] is high.
- Grant selection, evaluated in this order:
  - If the lock is held, only the lock owner can be granted.
  - Otherwise, if exactly one port is valid, that port wins.
  - Otherwise, if both ports are valid, the port named by rr_ptr wins.
- rr_ptr update: after a grant to port k, rr_ptr becomes !k.
- Lock behaviour:
  - A granted transfer with i_req_lock=1 sets lock_held=1 and lock_owner=k.
  - A granted transfer from the owner with i_req_lock=0 clears lock_held.
  - While the lock is held, the other port stalls even when the owner is idle.
- LSU drive signals:
  - o_lsu_addr, o_lsu_st_data and o_lsu_funct3 carry the winner's fields. When there is no grant they carry port 0's fields.
  - o_lsu_wren = grant & wren.
  - o_lsu_ren = grant & !wren.
  - Both enables are 0 when there is no grant.
- Response tracking:
  - On every transfer, register rsp_port=k, rsp_is_read=!wren and rsp_pend=1.
  - o_rsp_valid[rsp_port] = rsp_pend.
  - o_rsp_rdata = rsp_is_read ? i_ld_data : 32'b0.
  - Stores also receive a response pulse, with data 0.
- Responses are never back-pressured. The requester must accept the pulse.

## Timing
- Reset values: rr_ptr=0, lock_held=0, rsp_pend=0, wait counter=0.
  - Consequences during reset: o_rsp_valid=0, o_rsp_rdata=0, o_lsu_wren=0 and o_lsu_ren=0.
- Latency: a transfer in cycle N produces o_rsp_valid during cycle N+1, with the load data present in that same cycle.
- Throughput: one transfer per cycle. Back-to-back transfers from alternating or identical ports are legal.
  - Every cycle's response is independent; rsp_pend is rewritten each cycle.
- Reset asserted mid-operation: a pending response is dropped, o_rsp_valid is 0 in the following cycle, and the lock is released.
- Simultaneous events: a lock-release transfer from the owner and a request from the other port in the same cycle grant the owner only. The other port can win from the next cycle.

## Configuration
- Macro LSU_ARB_FIXED_PRIO_EN.
- Defined: port 0 has fixed priority.
  - An 8-bit wait counter increments in each cycle where port 1 is valid and not granted.
  - When the counter equals P_MAX_WAIT, port 1 wins the next contention, unless port 0 holds the lock.
  - The counter clears whenever port 1 is granted.
  - rr_ptr is not implemented.
- Undefined: round-robin arbitration as described under Operation. No wait counter exists.

## Structure
- Package lsu_arb_pkg holds:
  - typedef lsu_req_t, a struct of {valid, addr, wdata, wren, funct3, lock};
  - constants N_PORTS=2 and FUNCT3_LW=3'b010.
- Sub-module lsu_arb_grant: the purely combinational winner selection from the valid bits, rr_ptr/wait state and lock state.
- The top module holds all registers and the LSU/response muxing.

## Test plan
- Port 0 loads 0x0000_0010 (LW) in cycle N and the LSU returns 0xDEADBEEF in cycle N+1 -> o_rsp_valid=2'b01 and o_rsp_rdata=0xDEADBEEF in N+1.
- Both ports hold valid continuously for 4 cycles (round-robin build) -> grants go 0,1,0,1 and responses alternate 01,10,01,10.
- Port 1 issues a locked load to 0x100 and then an unlocked store, while port 0 is valid throughout -> port 0 is not granted until the cycle after the store. The store's response carries rdata=0.
- LSU_ARB_FIXED_PRIO_EN with P_MAX_WAIT=3, both ports valid continuously -> grants go 0,0,0,1,0,0,0,1.
- Reset asserted in the cycle after a port 0 load transfer -> o_rsp_valid stays 0 and no grant is given while reset is high.
- Store of 0xAA to address 0x1000_0000 by port 1 -> o_lsu_wren=1, o_lsu_addr=0x1000_0000 and o_lsu_st_data=0xAA in the transfer cycle. The next cycle shows o_rsp_valid=2'b10 with rdata=0.
